pc_fetch_unit: RTL and testbench

//  Fetch-stage consumer of the next-PC value: owns the F-stage PC register, drives the

---
 rtl/cpu_defs.sv | 18 +
 rtl/if_id_reg.sv | 34 +++
 rtl/pc_fetch_unit.sv | 104 ++++++++++
 tb/tb_pc_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset PC, bubble instruction and fetch-stage state encoding.
package cpu_defs;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_t;

  // A fetched word together with its address-error flag.
  typedef struct packed {
    logic [31:0] instr;
    logic        adel;
  } fetch_word_t;

endpackage

// File: rtl/if_id_reg.sv
// F->D pipeline register: PC, instruction, valid and fetch-fault flag, loaded on en.
module if_id_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        adel_in,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_valid,
  output logic        d_adel
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_pc    <= RESET_PC;
      d_instr <= NOP_INSTR;
      d_valid <= 1'b0;
      d_adel  <= 1'b0;
    end else if (en) begin
      d_pc    <= pc_in;
      d_instr <= instr_in;
      d_valid <= 1'b1;
      d_adel  <= adel_in;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns F_PC, runs the instruction-memory handshake and loads the F->D register.
module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic [31:0] F_PC,
  output logic        if_wait,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic        D_adel
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  f_pc_reg;
  fetch_word_t  buf_reg;
  fetch_word_t  live_word;
  fetch_word_t  hand_word;
  logic         misaligned;
  logic         fetch_done;
  logic         handoff;
  logic         buf_load;

  assign misaligned = |f_pc_reg[1:0];

  always_comb begin
    state_next = state_reg;
    im_req     = 1'b0;
    fetch_done = 1'b0;
    handoff    = 1'b0;
    buf_load   = 1'b0;
    // A misaligned PC completes immediately as a faulting bubble, never touching memory.
    live_word  = misaligned ? '{instr: NOP_INSTR, adel: 1'b1}
                            : '{instr: im_rdata,  adel: 1'b0};
    hand_word  = buf_reg;
    case (state_reg)
      S_REQ: begin
        im_req     = !misaligned && !reset;
        fetch_done = misaligned || im_ack;
        hand_word  = live_word;
        if (fetch_done) begin
          if (stall) begin
            buf_load   = 1'b1;
            state_next = S_HOLD;
          end else begin
            handoff = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          handoff    = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  assign if_wait = (state_reg == S_REQ) && !fetch_done;
  assign F_PC    = f_pc_reg;
  assign im_addr = f_pc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_REQ;
      f_pc_reg  <= RESET_PC;
      buf_reg   <= '{instr: NOP_INSTR, adel: 1'b0};
    end else begin
      state_reg <= state_next;
      if (handoff)
        f_pc_reg <= npc;
      if (buf_load)
        buf_reg <= live_word;
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (handoff),
    .pc_in   (f_pc_reg),
    .instr_in(hand_word.instr),
    .adel_in (hand_word.adel),
    .d_pc    (D_PC),
    .d_instr (D_instr),
    .d_valid (D_valid),
    .d_adel  (D_adel)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch sequences, D-register updates checked by a monitor.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic [31:0] F_PC;
  logic        if_wait;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_valid;
  logic        D_adel;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
    logic        valid;
  } d_tuple_t;

  d_tuple_t exp_q[$];
  d_tuple_t last_d;
  logic     mon_en = 1'b0;

  logic        npc_ovr_en = 1'b0;
  logic [31:0] npc_ovr    = 32'h0;
  int          ack_delay  = 0;
  int          wait_cnt;
  int          hs_cnt     = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk     (clk),
    .reset   (reset),
    .npc     (npc),
    .stall   (stall),
    .F_PC    (F_PC),
    .if_wait (if_wait),
    .im_req  (im_req),
    .im_addr (im_addr),
    .im_ack  (im_ack),
    .im_rdata(im_rdata),
    .D_PC    (D_PC),
    .D_instr (D_instr),
    .D_valid (D_valid),
    .D_adel  (D_adel)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // NPC stand-in: sequential unless a branch target is forced.
  always_comb npc = npc_ovr_en ? npc_ovr : F_PC + 32'd4;

  // Instruction memory with programmable wait states; data is junk unless acking.
  assign im_ack   = im_req && (wait_cnt >= ack_delay);
  assign im_rdata = im_ack ? word_of(im_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (im_req && !im_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) if (!reset && im_req && im_ack) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic adel,
                      input logic valid);
    exp_q.push_back('{pc: pc, instr: instr, adel: adel, valid: valid});
  endtask

  // Monitor: every change of the D register must match the next queued expectation.
  always @(posedge clk or posedge reset) begin
    d_tuple_t cur;
    d_tuple_t e;
    #2;
    cur = '{pc: D_PC, instr: D_instr, adel: D_adel, valid: D_valid};
    if (mon_en && cur != last_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL d_update: unexpected D=%h/%h/%b/%b, required no change",
                 cur.pc, cur.instr, cur.adel, cur.valid);
      end else begin
        e = exp_q.pop_front();
        if (cur != e) begin
          errors++;
          $display("FAIL d_update: actual pc=%h instr=%h adel=%b valid=%b required pc=%h instr=%h adel=%b valid=%b",
                   cur.pc, cur.instr, cur.adel, cur.valid, e.pc, e.instr, e.adel, e.valid);
        end else begin
          $display("ok   d_update: pc=%h instr=%h adel=%b valid=%b", cur.pc, cur.instr, cur.adel, cur.valid);
        end
      end
      last_d = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_start;
    reset = 1'b1;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_F_PC", F_PC, 32'h3000);
    chk("rst_D_PC", D_PC, 32'h3000);
    chk("rst_D_instr", D_instr, 32'h0);
    chk("rst_D_valid", {31'h0, D_valid}, 32'h0);
    chk("rst_D_adel", {31'h0, D_adel}, 32'h0);
    chk("rst_im_req", {31'h0, im_req}, 32'h0);
    last_d = '{pc: 32'h3000, instr: 32'h0, adel: 1'b0, valid: 1'b0};
    mon_en = 1'b1;

    // Zero-wait streaming.
    @(negedge clk); reset = 1'b0; #1;
    chk("zw_im_req", {31'h0, im_req}, 32'h1);
    chk("zw_F_PC0", F_PC, 32'h3000);
    push(32'h3000, word_of(32'h3000), 1'b0, 1'b1);
    @(negedge clk);
    ack_delay = 3; #1;
    chk("zw_F_PC1", F_PC, 32'h3004);

    // Three wait states at 3004.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("ws_if_wait", {31'h0, if_wait}, 32'h1);
      chk("ws_im_addr", im_addr, 32'h3004);
      chk("ws_D_PC", D_PC, 32'h3000);
    end
    @(negedge clk); #1;
    chk("ws_done_if_wait", {31'h0, if_wait}, 32'h0);
    push(32'h3004, word_of(32'h3004), 1'b0, 1'b1);
    @(negedge clk);
    ack_delay = 0;
    hs_start = hs_cnt;
    stall = 1'b1; #1;
    chk("st_F_PC", F_PC, 32'h3008);
    chk("st_if_wait", {31'h0, if_wait}, 32'h0);

    // Stalled fetch lands in the hold buffer, then branches after the delay slot.
    @(negedge clk); #1;
    chk("hold_im_req", {31'h0, im_req}, 32'h0);
    chk("hold_if_wait", {31'h0, if_wait}, 32'h0);
    chk("hold_F_PC", F_PC, 32'h3008);
    chk("hold_D_PC", D_PC, 32'h3004);
    stall = 1'b0;
    npc_ovr_en = 1'b1; npc_ovr = 32'h3100;
    push(32'h3008, word_of(32'h3008), 1'b0, 1'b1);
    #1;
    chk("hold2_im_req", {31'h0, im_req}, 32'h0);
    @(negedge clk);
    npc_ovr_en = 1'b0; #1;
    chk("br_F_PC", F_PC, 32'h3100);
    chk("st_single_req", hs_cnt - hs_start, 32'd1);
    push(32'h3100, word_of(32'h3100), 1'b0, 1'b1);

    // Misaligned target faults without touching memory.
    @(negedge clk);
    npc_ovr_en = 1'b1; npc_ovr = 32'h3002; #1;
    chk("ma_pre_F_PC", F_PC, 32'h3104);
    push(32'h3104, word_of(32'h3104), 1'b0, 1'b1);
    @(negedge clk);
    npc_ovr_en = 1'b0; #1;
    chk("ma_F_PC", F_PC, 32'h3002);
    chk("ma_im_req", {31'h0, im_req}, 32'h0);
    chk("ma_if_wait", {31'h0, if_wait}, 32'h0);
    push(32'h3002, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    npc_ovr_en = 1'b1; npc_ovr = 32'h3010; #1;
    chk("ma2_F_PC", F_PC, 32'h3006);
    chk("ma2_im_req", {31'h0, im_req}, 32'h0);
    push(32'h3006, 32'h0, 1'b1, 1'b1);

    // Reset asserted in the middle of a memory wait.
    @(negedge clk);
    npc_ovr_en = 1'b0;
    ack_delay = 5; #1;
    chk("rw_F_PC", F_PC, 32'h3010);
    chk("rw_if_wait", {31'h0, if_wait}, 32'h1);
    @(negedge clk); #1;
    chk("rw_im_addr", im_addr, 32'h3010);
    push(32'h3000, 32'h0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("rw_rst_F_PC", F_PC, 32'h3000);
    chk("rw_rst_D_valid", {31'h0, D_valid}, 32'h0);
    chk("rw_rst_im_req", {31'h0, im_req}, 32'h0);
    ack_delay = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("rf_im_req", {31'h0, im_req}, 32'h1);
    chk("rf_im_addr", im_addr, 32'h3000);
    push(32'h3000, word_of(32'h3000), 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("rf_F_PC", F_PC, 32'h3004);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
